// File: rtl/imm_ext_pipe.sv
// Immediate / load-data extension unit with a small output FIFO.
// The result is computed at accept time; only results, tags and flags are queued.
module imm_ext_pipe #(
  parameter int OUT_W = 32,
  parameter int IMM_W = 16,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OUT_W-1:0]               in_data,
  input  logic [2:0]                     in_mode,
  input  logic [$clog2(OUT_W/8)-1:0]     in_ofs,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           out_illegal,
  output logic                           out_misalign,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int NLANE = OUT_W / 8;
  localparam int OFS_W = $clog2(NLANE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] MODE_SEXT = 3'd0;
  localparam logic [2:0] MODE_ZEXT = 3'd1;
  localparam logic [2:0] MODE_LUI  = 3'd2;
  localparam logic [2:0] MODE_LB   = 3'd3;
  localparam logic [2:0] MODE_LBU  = 3'd4;
  localparam logic [2:0] MODE_LH   = 3'd5;
  localparam logic [2:0] MODE_LHU  = 3'd6;
  localparam logic [2:0] MODE_ILL  = 3'd7;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             ill;
    logic             mis;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [IMM_W-1:0]   imm_s;
  logic [7:0]         byte_s;
  logic [15:0]        half_s;
  entry_t             res_s;
  logic               push_s;
  logic               pop_s;

  assign imm_s = in_data[IMM_W-1:0];

  // Lane selection and per-mode extension of the incoming request.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    res_s  = '0;
    for (int k = 0; k < NLANE; k++) begin
      byte_s = (in_ofs == OFS_W'(k)) ? in_data[8*k +: 8] : byte_s;
    end
    // Halfword address ignores ofs[0]; misalignment is only flagged.
    for (int k = 0; k < NLANE / 2; k++) begin
      half_s = (in_ofs[OFS_W-1:1] == (OFS_W-1)'(k)) ? in_data[16*k +: 16] : half_s;
    end
    res_s.tag = in_tag;
    case (in_mode)
      MODE_SEXT: res_s.data = {{(OUT_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
      MODE_ZEXT: res_s.data = {{(OUT_W-IMM_W){1'b0}}, imm_s};
      MODE_LUI:  res_s.data = {imm_s, {(OUT_W-IMM_W){1'b0}}};
      MODE_LB:   res_s.data = {{(OUT_W-8){byte_s[7]}}, byte_s};
      MODE_LBU:  res_s.data = {{(OUT_W-8){1'b0}}, byte_s};
      MODE_LH: begin
        res_s.data = {{(OUT_W-16){half_s[15]}}, half_s};
        res_s.mis  = in_ofs[0];
      end
      MODE_LHU: begin
        res_s.data = {{(OUT_W-16){1'b0}}, half_s};
        res_s.mis  = in_ofs[0];
      end
      MODE_ILL:  res_s.ill = 1'b1;
      default:   res_s.ill = 1'b1;
    endcase
  end

  // Handshake, pointer and occupancy next-state; outputs come from registered state.
  always_comb begin
    in_ready  = (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != CNT_W'(0));
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    wr_ptr_d  = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = res_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    count = count_q;
  end

  // Head entry drives the result beat; everything reads zero when empty.
  always_comb begin
    if (count_q != CNT_W'(0)) begin
      out_data     = mem_q[rd_ptr_q].data;
      out_tag      = mem_q[rd_ptr_q].tag;
      out_illegal  = mem_q[rd_ptr_q].ill;
      out_misalign = mem_q[rd_ptr_q].mis;
    end else begin
      out_data     = '0;
      out_tag      = '0;
      out_illegal  = 1'b0;
      out_misalign = 1'b0;
    end
  end

  // State registers; reset discards every queued beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: default DEPTH=2 instance for modes, backpressure
// and reset; a DEPTH=4 instance for ordered streaming with pointer wrap.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, out_illegal, out_misalign;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_mode;
  logic [1:0]  in_ofs;
  logic [4:0]  in_tag, out_tag;
  logic [1:0]  count;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_illegal4, out_misalign4;
  logic [31:0] in_data4, out_data4;
  logic [2:0]  in_mode4;
  logic [1:0]  in_ofs4;
  logic [4:0]  in_tag4, out_tag4;
  logic [2:0]  count4;

  int n_checks = 0;
  int n_errors = 0;
  int vec_idx  = 0;

  imm_ext_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .in_ofs(in_ofs), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_illegal(out_illegal), .out_misalign(out_misalign), .count(count)
  );

  imm_ext_pipe #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
    .in_ofs(in_ofs4), .in_tag(in_tag4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_tag(out_tag4),
    .out_illegal(out_illegal4), .out_misalign(out_misalign4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] mode, input logic [31:0] data,
                      input logic [1:0] ofs, input logic [4:0] tag);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    in_ofs   = ofs;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_mode  = 3'd7;
  endtask

  task automatic run_vec(input string name, input logic [2:0] mode, input logic [31:0] data,
                         input logic [1:0] ofs, input logic [31:0] exp,
                         input logic ill, input logic mis);
    vec_idx++;
    send(mode, data, ofs, 5'(vec_idx));
    check_eq({name, "_valid"}, out_valid, 1'b1);
    check_eq({name, "_data"}, out_data, exp);
    check_eq({name, "_tag"}, out_tag, 5'(vec_idx));
    check_eq({name, "_ill"}, out_illegal, ill);
    check_eq({name, "_mis"}, out_misalign, mis);
    check_eq({name, "_count"}, count, 2'd1);
  endtask

  logic [36:0] exp_q[$];
  logic [36:0] head;
  int          sent, rcvd, max_cnt;
  logic        push4, pop4;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 32'h0; in_mode = 3'd0; in_ofs = 2'd0; in_tag = 5'd0;
    out_ready = 1'b1;
    in_valid4 = 1'b0; in_data4 = 32'h0; in_mode4 = 3'd1; in_ofs4 = 2'd0; in_tag4 = 5'd0;
    out_ready4 = 1'b0;
    #3;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_count", count, 2'd0);
    check_eq("rst_data", out_data, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Mode vectors; each accept also pops the previous head (count stays 1).
    run_vec("sext",     3'd0, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0, 1'b0);
    run_vec("sext_pos", 3'd0, 32'hABCD_7FFF, 2'd3, 32'h0000_7FFF, 1'b0, 1'b0);
    run_vec("zext",     3'd1, 32'hABCD_8001, 2'd1, 32'h0000_8001, 1'b0, 1'b0);
    run_vec("lui",      3'd2, 32'h0000_1234, 2'd0, 32'h1234_0000, 1'b0, 1'b0);
    run_vec("lui_junk", 3'd2, 32'hFFFF_00FF, 2'd2, 32'h00FF_0000, 1'b0, 1'b0);
    run_vec("lb2",      3'd3, 32'h1280_7F00, 2'd2, 32'hFFFF_FF80, 1'b0, 1'b0);
    run_vec("lbu2",     3'd4, 32'h1280_7F00, 2'd2, 32'h0000_0080, 1'b0, 1'b0);
    run_vec("lb1",      3'd3, 32'h1280_7F00, 2'd1, 32'h0000_007F, 1'b0, 1'b0);
    run_vec("lb3",      3'd3, 32'h1280_7F00, 2'd3, 32'h0000_0012, 1'b0, 1'b0);
    run_vec("lh3_mis",  3'd5, 32'h8000_1234, 2'd3, 32'hFFFF_8000, 1'b0, 1'b1);
    run_vec("lhu0",     3'd6, 32'h8000_1234, 2'd0, 32'h0000_1234, 1'b0, 1'b0);
    run_vec("lh1_mis",  3'd5, 32'h8000_1234, 2'd1, 32'h0000_1234, 1'b0, 1'b1);
    run_vec("lhu2",     3'd6, 32'h8000_1234, 2'd2, 32'h0000_8000, 1'b0, 1'b0);
    run_vec("illegal",  3'd7, 32'h1234_5678, 2'd0, 32'h0000_0000, 1'b1, 1'b0);
    step();
    check_eq("drain_valid", out_valid, 1'b0);
    check_eq("drain_data", out_data, 32'h0);
    check_eq("drain_ill", out_illegal, 1'b0);

    // Backpressure: fill, hold stable, rejected push while full.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0011, 2'd0, 5'd1);
    send(3'd1, 32'h0000_0022, 2'd0, 5'd2);
    check_eq("full_count", count, 2'd2);
    check_eq("full_ready", in_ready, 1'b0);
    check_eq("full_tag", out_tag, 5'd1);
    step();
    check_eq("hold_tag", out_tag, 5'd1);
    check_eq("hold_data", out_data, 32'h0000_0011);
    in_valid = 1'b1; in_mode = 3'd1; in_data = 32'h0000_0033; in_tag = 5'd3;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("rej_count", count, 2'd1);
    check_eq("rej_ready", in_ready, 1'b1);
    check_eq("rej_tag", out_tag, 5'd2);
    check_eq("rej_data", out_data, 32'h0000_0022);
    step();
    check_eq("rej_empty", out_valid, 1'b0);

    // Asynchronous reset mid-cycle with two beats queued.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0044, 2'd0, 5'd4);
    send(3'd1, 32'h0000_0055, 2'd0, 5'd5);
    check_eq("pre_rst_count", count, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_count", count, 2'd0);
    check_eq("arst_ready", in_ready, 1'b1);
    check_eq("arst_data", out_data, 32'h0);
    check_eq("arst_tag", out_tag, 5'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check_eq("post_rst_valid", out_valid, 1'b0);
    send(3'd0, 32'h0000_FF80, 2'd0, 5'd9);
    check_eq("post_rst_data", out_data, 32'hFFFF_FF80);
    check_eq("post_rst_tag", out_tag, 5'd9);
    step();

    // DEPTH=4 streaming with random backpressure.
    sent = 0; rcvd = 0; max_cnt = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 10; cyc++) begin
      in_valid4  = (sent < 10);
      in_data4   = {16'hDEAD, 16'(sent * 257 + 7)};
      in_tag4    = 5'(sent);
      in_mode4   = 3'd1;
      out_ready4 = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      push4 = in_valid4 && in_ready4;
      pop4  = out_valid4 && out_ready4;
      if (pop4) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          head = exp_q.pop_front();
          check_eq("d4_data", out_data4, head[31:0]);
          check_eq("d4_tag", out_tag4, head[36:32]);
          rcvd++;
        end
      end
      if (push4) begin
        exp_q.push_back({5'(sent), 16'h0000, 16'(sent * 257 + 7)});
        sent++;
      end
      step();
      if (int'(count4) > max_cnt) max_cnt = int'(count4);
    end
    in_valid4 = 1'b0;
    check_eq("d4_received", rcvd, 10);
    check_eq("d4_max_count", max_cnt, 4);
    check_eq("d4_empty", out_valid4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter OUT_W, default 32, output datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter IMM_W, default 16, immediate field width; 8 <= IMM_W < OUT_W.
REQ-003 SHALL have parameter DEPTH, default 2, output queue entries; power of two, >= 2.
REQ-004 SHALL have parameter TAG_W, default 5, sideband tag width (destination register number).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, request present.
REQ-008 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-009 SHALL have port in_data, input, OUT_W, source: immediate in low IMM_W bits, or load word.
REQ-010 SHALL have port in_mode, input, 3, extension mode (REQ-016).
REQ-011 SHALL have port in_ofs, input, $clog2(OUT_W/8), byte offset for load modes.
REQ-012 SHALL have port in_tag, input, TAG_W, carried unchanged to out_tag.
REQ-013 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W), out_tag (output, TAG_W): the result beat.
REQ-014 SHALL have ports out_illegal (output, 1) and out_misalign (output, 1): per-beat flags, valid with out_valid.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, current queue occupancy.

Function
REQ-016 SHALL compute the result per in_mode; lane k = in_data[8k+7:8k], little-endian:
 - 0 SEXT: in_data[IMM_W-1:0] sign-extended to OUT_W.
 - 1 ZEXT: in_data[IMM_W-1:0] zero-extended.
 - 2 LUI: in_data[IMM_W-1:0] placed at bits [OUT_W-1:OUT_W-IMM_W], lower bits zero.
 - 3 LB / 4 LBU: byte lane in_ofs, sign- / zero-extended.
 - 5 LH / 6 LHU: halfword at lanes {in_ofs with bit0 cleared, +1}, sign- / zero-extended.
 - 7: out_data = 0, out_illegal = 1.
REQ-017 SHALL set out_misalign = 1 for modes 5/6 with in_ofs[0] = 1, computing data with in_ofs[0] treated as 0; out_misalign = 0 in all other modes.
REQ-018 SHALL ignore the in_ofs value in modes 0, 1, 2 and 7.
REQ-019 SHALL accept a request when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-020 SHALL compute the result combinationally at accept and store result, tag and flags in a DEPTH-entry FIFO; no raw inputs are stored.
REQ-021 SHALL have latency exactly 1 cycle: a beat accepted at edge N into an empty queue has out_valid = 1 after edge N.
REQ-022 SHALL drive out_data, out_tag, out_illegal and out_misalign from the head entry; all are zero when count = 0.
REQ-023 SHALL drive in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-024 SHALL drive out_valid = (count != 0).
REQ-025 SHALL handle simultaneous accept and pop when 0 < count < DEPTH as count unchanged and order preserved.
REQ-026 SHALL NOT accept when full, even if a pop occurs in the same cycle; in_ready returns 1 the cycle after the pop.
REQ-027 SHALL hold the head beat and all out_* signals stable while out_valid && !out_ready.
REQ-028 SHALL use read/write pointers that wrap modulo DEPTH; FIFO order is strict.
REQ-029 SHALL ignore in_* entirely when in_valid = 0.

Reset
REQ-030 SHALL, while rst_n = 0 and regardless of clk, clear pointers and count and discard all queued beats; out_valid, out_data, out_tag, out_illegal, out_misalign and count read 0, and in_ready reads 1.
REQ-031 SHALL flush any in-flight beat on a reset asserted mid-operation; no stale beat appears after release.
REQ-032 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL pass: defaults, mode 0, in_data = 0x0000_8001, out_ready = 1 -> next cycle out_valid = 1, out_data = 0xFFFF_8001, flags 0.
REQ-034 SHALL pass: LUI 0x1234 -> 0x1234_0000; LB in_data 0x1280_7F00, ofs 2 -> 0xFFFF_FF80; LBU ofs 2 -> 0x0000_0080.
REQ-035 SHALL pass: LH in_data 0x8000_1234, ofs 3 -> out_misalign = 1, out_data = 0xFFFF_8000; mode 7 -> out_data = 0, out_illegal = 1.
REQ-036 SHALL pass: out_ready = 0, push tags 1, 2 -> count = 2, in_ready = 0, out_tag = 1 stable. A third push with out_ready = 1 in the same cycle is rejected; in_ready = 1 next cycle. Tags then drain 1, 2.
REQ-037 SHALL pass: DEPTH = 4, 10 beats with random out_ready -> results in order with pointer wrap, and count never exceeds 4.
REQ-038 SHALL pass: rst_n pulsed low between clock edges with count = 2 -> outputs 0 and in_ready = 1 immediately; no beats after release.
